seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Consumer end of the packed 32-bit `seg_display` bus that every puzzle block produces. It takes 8 packed nibbles (digit 7 = bits [31:28] = leftmost, digit 0 = bits [3:0] = rightmost), time-multiplexes them onto one shared 8-line segment bus plus 8 digit enables, and adds decimal-point and blink control. It sits at the top level between the puzzle mux and the board's 8-digit 7-segment module.

Parameters:
SCAN_DIV, 10000, clk cycles per digit slot; must be >= 2.
DEAD_CYCLES, 16, cycles at the start of each slot with all digit enables off (anti-ghosting); must be < SCAN_DIV.
BLINK_DIV, 50, frames per blink half-period; must be >= 1.
SEG_ACTIVE_LOW, 0, 1 inverts `seg_out`.
DIG_ACTIVE_LOW, 0, 1 inverts `digit_sel`.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable
disp_data  in  32  packed nibbles: 0-9 digits, A-E hex letters, F = blank
dp_mask  in  8  bit i lights the decimal point of digit i
blink_mask  in  8  bit i makes digit i blink
digit_sel  out  8  one-hot digit enable, bit i = digit i
seg_out  out  8  {dp,g,f,e,d,c,b,a}
frame_tick  out  1  1-cycle pulse at each frame start

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low (`rst_n`).
- Reset values:
  - `digit_sel` and `seg_out` inactive. Inactive means all 0 before the polarity parameters are applied.
  - `frame_tick` = 0, prescaler = 0, digit index = 0.
  - Blink phase = 0, blink frame counter = 0.
  - Shadow data = 32'hFFFF_FFFF; shadow dp and blink masks = 0.
- Prescaler:
  - `pcnt` counts 0..SCAN_DIV-1 while `enable` = 1.
  - At terminal count, `pcnt` wraps to 0 and digit index `idx` increments 0..7, wrapping 7 -> 0.
  - Scan order is 0, 1, ..., 7.
- Frame start: the `idx` wrap 7 -> 0 at terminal count. In that same cycle:
  - Shadow registers load `disp_data`, `dp_mask` and `blink_mask`.
  - `frame_tick` is registered high for exactly 1 cycle.
  - Inputs are otherwise ignored mid-frame, so no tearing.
- Blink:
  - The frame counter counts frames 0..BLINK_DIV-1.
  - On its wrap, blink phase toggles.
  - While phase = 1, every digit whose shadow blink bit is set is fully blanked, decimal point included.
- Decode, active-high, before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79.
  - F=00 (blank); hex F is not displayable.
  - dp (bit 7) = shadow `dp_mask[idx]`, independent of the nibble, except when blink-blanked.
- Outputs are registered: `seg_out` and `digit_sel` reflect the (`idx`, `pcnt`) state of the previous cycle, i.e. one cycle latency.
- `digit_sel` = one-hot(`idx`), except all-inactive while `pcnt` < DEAD_CYCLES. `seg_out` stays driven during dead time.
- `enable` = 0:
  - `pcnt`, `idx`, blink phase and frame counter are held at 0.
  - Shadows load inputs every cycle (transparent).
  - Outputs are inactive; `frame_tick` = 0.
- `enable` 0 -> 1: the scan starts at digit 0, `pcnt` = 0, showing the data present on the last disabled cycle.
- Reset mid-frame: immediate return to reset values; no partial-frame output.

Decomposition:
- Package `seg7_pkg` holds:
  - `NUM_DIGITS` = 8 and `BLANK_CODE` = 4'hF.
  - The 16-entry segment pattern constants.
  - A typedef for the 8-bit segment vector.
- Sub-module `seg7_decode` is purely combinational: nibble + dp + blank in, 8-bit active-high pattern out.
- `seg7_scan_driver` owns the prescaler, index, blink counters, shadows, polarity and output registers.

Test Plan:
All scenarios use SCAN_DIV=4, DEAD_CYCLES=1, BLINK_DIV=2, active-high polarity.
1. Reset, `enable`=1, `disp_data`=32'h12FF_FF25.
   - Per slot: digit0 seg 6D, digit1 5B, digits2-5 00, digit6 5B, digit7 06.
   - `digit_sel` = 00 in the first cycle of each slot, then the one-hot bit.
2. Change `disp_data` mid-frame to 32'h8888_8888.
   - The current frame still shows the old values.
   - From the cycle after `frame_tick`, every digit shows 7F.
   - `frame_tick` occurs every 32 cycles.
3. `dp_mask`=8'h04, `disp_data`=all F -> digit2 seg 80, all other digits 00.
4. `blink_mask`=8'h01, `disp_data`=...0003 -> digit0 shows 4F for 2 frames, 00 for 2 frames, repeating; other digits are unaffected.
5. Drop `enable` mid-frame, then raise it.
   - While disabled: outputs are 00 and `frame_tick` stays 0.
   - The scan restarts at digit0 with the latest data.
6. Assert `rst_n` low while digit5 is lit -> `digit_sel`/`seg_out` = 00 immediately, without a clock edge; after release all digits are blank until the first frame latch.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan driver.
// Patterns are active-high {g,f,e,d,c,b,a}; the dp bit is added separately.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [7:0] seg8_t;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h00
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high segment pattern; blank suppresses the dp as well.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output seg8_t      seg
);

    always_comb begin
        seg = '0;
        if (!blank) begin
            seg[7] = dp;
            if (nibble != BLANK_CODE)
                seg[6:0] = SEG_LUT[nibble];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit scan with frame-latched shadows, dead time,
// decimal points, blink and output polarity control.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEAD_CYCLES    = 16,
    parameter int BLINK_DIV      = 50,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [31:0]           disp_data,
    input  logic [7:0]            dp_mask,
    input  logic [7:0]            blink_mask,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output seg8_t                 seg_out,
    output logic                  frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PC_DEAD = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BLINK_DIV - 1);

    localparam seg8_t SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PW-1:0] pcnt;
    logic [IW-1:0] idx;
    logic [BW-1:0] fcnt;
    logic          phase;
    logic [31:0]   sh_data;
    logic [7:0]    sh_dp;
    logic [7:0]    sh_blink;

    logic                  pc_last;
    logic                  frame_start;
    logic                  in_dead;
    logic [NUM_DIGITS-1:0] one_hot;
    seg8_t                 seg_nxt;

    assign pc_last     = (pcnt == PC_LAST);
    assign frame_start = pc_last && (idx == IDX_LAST);
    assign in_dead     = (pcnt < PC_DEAD);
    assign one_hot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

    seg7_decode u_decode (
        .nibble (sh_data[{idx, 2'b00} +: 4]),
        .dp     (sh_dp[idx]),
        .blank  (phase & sh_blink[idx]),
        .seg    (seg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            sh_data    <= 32'hFFFF_FFFF;
            sh_dp      <= '0;
            sh_blink   <= '0;
            frame_tick <= 1'b0;
            digit_sel  <= DIG_OFF;
            seg_out    <= SEG_OFF;
        end else if (!enable) begin
            // Idle: shadows track inputs so a restart shows fresh data.
            pcnt       <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            sh_data    <= disp_data;
            sh_dp      <= dp_mask;
            sh_blink   <= blink_mask;
            frame_tick <= 1'b0;
            digit_sel  <= DIG_OFF;
            seg_out    <= SEG_OFF;
        end else begin
            frame_tick <= frame_start;
            if (pc_last) begin
                pcnt <= '0;
                idx  <= idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (frame_start) begin
                sh_data  <= disp_data;
                sh_dp    <= dp_mask;
                sh_blink <= blink_mask;
                if (fcnt == BC_LAST) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            digit_sel <= in_dead ? DIG_OFF : (one_hot ^ DIG_OFF);
            seg_out   <= seg_nxt ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scan driver bench: directed scenarios plus random traffic against a
// cycle-count based reference model.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] disp_data;
    logic [7:0]  dp_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  digit_sel;
    logic [7:0]  seg_out;
    logic        frame_tick;

    int npass;
    int ntotal;

    int          m_t;
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic [7:0]  m_bl;
    int          m_lastd;
    int          m_lastp;

    seg7_scan_driver #(
        .SCAN_DIV       (4),
        .DEAD_CYCLES    (1),
        .BLINK_DIV      (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .disp_data  (disp_data),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .digit_sel  (digit_sel),
        .seg_out    (seg_out),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pat(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};
        return tbl[n];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, m_t);
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_data = 32'hFFFF_FFFF;
        m_dp   = '0;
        m_bl   = '0;
    endtask

    // One clock: model the state processed at this edge, then check #1 later.
    task automatic step();
        logic [7:0] es;
        logic [7:0] ed;
        logic       ef;
        int d, p, k;
        logic ph;
        @(posedge clk);
        es = '0;
        ed = '0;
        ef = 1'b0;
        m_lastd = -1;
        m_lastp = -1;
        if (!rst_n) begin
            model_reset();
        end else if (!enable) begin
            m_t    = 0;
            m_data = disp_data;
            m_dp   = dp_mask;
            m_bl   = blink_mask;
        end else begin
            d  = (m_t / 4) % 8;
            p  = m_t % 4;
            k  = m_t / 32;
            ph = ((k / 2) % 2) == 1;
            if (!(ph && m_bl[d]))
                es = pat(m_data[d*4 +: 4]) | {m_dp[d], 7'b0};
            ed = (p < 1) ? 8'h00 : (8'h01 << d);
            ef = (m_t % 32) == 31;
            if (ef) begin
                m_data = disp_data;
                m_dp   = dp_mask;
                m_bl   = blink_mask;
            end
            m_lastd = d;
            m_lastp = p;
            m_t++;
        end
        #1;
        chk("seg_out", seg_out, es);
        chk("digit_sel", digit_sel, ed);
        chk("frame_tick", {7'b0, frame_tick}, {7'b0, ef});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int ph);
        int guard;
        guard = 0;
        while ((m_t % 32) != ph && guard < 100) begin
            step();
            guard++;
        end
    endtask

    initial begin
        int guard;
        npass  = 0;
        ntotal = 0;
        model_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        disp_data  = 32'h12FF_FF25;
        dp_mask    = '0;
        blink_mask = '0;
        #1;
        chk("reset_seg", seg_out, 8'h00);
        chk("reset_dsel", digit_sel, 8'h00);
        run(2);
        rst_n = 1'b1;

        // Basic scan: first frame blank, then latched digits.
        run(70);

        // Mid-frame data change must not tear the current frame.
        run_to_phase(10);
        disp_data = 32'h8888_8888;
        run(60);

        // Decimal point on a blank digit.
        dp_mask   = 8'h04;
        disp_data = 32'hFFFF_FFFF;
        run(70);

        // Blink on digit 0.
        dp_mask    = 8'h00;
        blink_mask = 8'h01;
        disp_data  = 32'hFFFF_FFF3;
        run(32 * 6);

        // Disable mid-frame, change data while idle, re-enable.
        run_to_phase(13);
        enable = 1'b0;
        run(5);
        disp_data  = 32'h0123_4567;
        blink_mask = 8'h00;
        dp_mask    = 8'hA5;
        run(2);
        enable = 1'b1;
        run(40);

        // Random traffic including short enable drops.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) disp_data = $urandom;
            if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            step();
        end
        enable     = 1'b1;
        disp_data  = 32'h0065_4321;
        blink_mask = 8'h00;
        run(70);

        // Async reset while digit 5 is lit.
        guard = 0;
        while (!(m_lastd == 5 && m_lastp == 2) && guard < 300) begin
            step();
            guard++;
        end
        chk("reach_digit5", digit_sel, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", seg_out, 8'h00);
        chk("async_rst_dsel", digit_sel, 8'h00);
        chk("async_rst_ft", {7'b0, frame_tick}, 8'h00);
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(45);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
